cypher_seq_detector: RTL

Parametrised streaming cypher detector, successor to the fixed 4x4-bit detector. Compares incoming symbols, one per valid strobe, against a programmable cypher of SEQ_LEN symbols of SYM_W bits each. On each full-sequence hit it emits a one-cycle pulse and bumps a saturating match counter. Overlapping or non-overlapping detection is selected per instance. Sits between the symbol source (input selector) and the result/status logic.

---
 rtl/cypher_seq_detector.sv | 94 +++++++++
 1 files changed

// File: rtl/cypher_seq_detector.sv
// Streaming cypher detector: programmable SEQ_LEN x SYM_W pattern,
// one-cycle hit pulse, saturating match counter with sticky overflow.
module cypher_seq_detector #(
  parameter int SYM_W   = 4,
  parameter int SEQ_LEN = 4,
  parameter int CNT_W   = 8,
  parameter int OVERLAP = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [SYM_W*SEQ_LEN-1:0]     cypher,
  input  logic                         load_cypher,
  input  logic [SYM_W-1:0]             symbol_in,
  input  logic                         symbol_valid,
  input  logic                         clear_count,
  output logic                         collected_signal,
  output logic [CNT_W-1:0]             match_count,
  output logic [$clog2(SEQ_LEN+1)-1:0] progress,
  output logic                         overflow
);

  localparam int W  = SYM_W * SEQ_LEN;
  localparam int PW = $clog2(SEQ_LEN + 1);
  localparam logic [PW-1:0] FULL = PW'(SEQ_LEN);

  logic [W-1:0]     r_cypher;
  logic [W-1:0]     r_window;
  logic [PW-1:0]    r_fill;
  logic [CNT_W-1:0] r_count;
  logic             r_pulse;
  logic             r_ovf;

  logic [W-1:0]     w_window_next;
  logic [PW-1:0]    w_fill_next;
  logic             w_accept;
  logic             w_match;

  // Post-shift window/fill and the match decision; newest symbol
  // enters the top slot so slot 0 always holds the oldest one.
  always_comb begin
    w_accept      = symbol_valid && !load_cypher;
    w_window_next = {symbol_in, r_window[W-1:SYM_W]};
    w_fill_next   = (r_fill == FULL) ? FULL : r_fill + PW'(1);
    w_match       = w_accept
                 && (w_fill_next == FULL)
                 && (w_window_next == r_cypher);
  end

  // Cypher register, symbol window and fill level.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cypher <= '0;
      r_window <= '0;
      r_fill   <= '0;
    end else if (load_cypher) begin
      r_cypher <= cypher;
      r_window <= '0;
      r_fill   <= '0;
    end else if (symbol_valid) begin
      r_window <= w_window_next;
      if (w_match && (OVERLAP == 0))
        r_fill <= '0;
      else
        r_fill <= w_fill_next;
    end
  end

  // Hit pulse, saturating counter and sticky overflow; a clear that
  // lands on a match edge still counts that match.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pulse <= 1'b0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_pulse <= w_match;
      if (clear_count) begin
        r_count <= w_match ? CNT_W'(1) : '0;
        r_ovf   <= 1'b0;
      end else if (w_match) begin
        if (&r_count)
          r_ovf <= 1'b1;
        else
          r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign collected_signal = r_pulse;
  assign match_count      = r_count;
  assign progress         = r_fill;
  assign overflow         = r_ovf;

endmodule
